// File: rtl/hsv_mode_ctrl.sv
// hsv_mode_ctrl
//   Holds the working HSV colour triple and updates it according to the
//   mode index coming from the button-driven mode selector: fixed presets,
//   periodic hue stepping, or direct load from the switch inputs.
//
// Ports:
//   clk      system clock (10 MHz)
//   reset    synchronous, active-high
//   sost     mode index 0..6 from the mode selector (7..15 illegal)
//   sw_h     switch hue, clamped to 0..359 when loaded
//   sw_s     switch saturation, clamped to 0..100 when loaded
//   sw_v     switch value, clamped to 0..100 when loaded
//   hue      current hue 0..359
//   sat      current saturation 0..100
//   val      current value 0..100
//   hsv_upd  one-cycle pulse in the cycle a changed {hue,sat,val} appears
//   mode_err high while the registered mode index is 7..15
module hsv_mode_ctrl #(
  parameter int STEP_CYCLES = 1000000,
  parameter int HUE_PRESET  = 120,
  parameter int HUE_JUMP    = 60,
  parameter int SV_PRESET   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sost,
  input  logic [8:0] sw_h,
  input  logic [6:0] sw_s,
  input  logic [6:0] sw_v,
  output logic [8:0] hue,
  output logic [6:0] sat,
  output logic [6:0] val,
  output logic       hsv_upd,
  output logic       mode_err
);

  typedef enum logic [3:0] {
    M_HUE_PRESET = 4'd0,
    M_HUE_JUMP   = 4'd1,
    M_HUE_CREEP  = 4'd2,
    M_HUE_SW     = 4'd3,
    M_VAL_SW     = 4'd4,
    M_SAT_SW     = 4'd5,
    M_SV_PRESET  = 4'd6
  } mode_t;

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(STEP_CYCLES - 1);

  logic [3:0]    sost_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          tick;
  logic          mode_change;
  logic          step_en;
  logic [9:0]    hue_jump_sum;
  logic [9:0]    hue_creep_sum;
  logic [8:0]    hue_n;
  logic [6:0]    sat_n;
  logic [6:0]    val_n;

  assign tick        = (count == COUNT_LAST);
  assign mode_change = (sost != sost_q);
  // A mode change coinciding with a tick suppresses the old mode's step.
  assign step_en     = tick && !mode_change;
  assign mode_err    = (sost_q > 4'd6);

  always_comb begin
    count_n = count + 1'b1;
    if (mode_change || tick) begin
      count_n = '0;
    end
  end

  always_comb begin
    hue_n = hue;
    sat_n = sat;
    val_n = val;

    // 10-bit sums so the add never overflows before the wrap compare.
    hue_jump_sum = {1'b0, hue} + 10'(HUE_JUMP);
    if (hue_jump_sum >= 10'd360) begin
      hue_jump_sum = hue_jump_sum - 10'd360;
    end
    hue_creep_sum = {1'b0, hue} + 10'd1;
    if (hue_creep_sum >= 10'd360) begin
      hue_creep_sum = '0;
    end

    case (sost_q)
      M_HUE_PRESET: hue_n = 9'(HUE_PRESET);
      M_HUE_JUMP:   if (step_en) hue_n = hue_jump_sum[8:0];
      M_HUE_CREEP:  if (step_en) hue_n = hue_creep_sum[8:0];
      M_HUE_SW:     hue_n = (sw_h > 9'd359) ? 9'd359 : sw_h;
      M_VAL_SW:     val_n = (sw_v > 7'd100) ? 7'd100 : sw_v;
      M_SAT_SW:     sat_n = (sw_s > 7'd100) ? 7'd100 : sw_s;
      M_SV_PRESET: begin
        sat_n = 7'(SV_PRESET);
        val_n = 7'(SV_PRESET);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sost_q  <= '0;
      count   <= '0;
      hue     <= 9'd120;
      sat     <= 7'd100;
      val     <= 7'd100;
      hsv_upd <= 1'b0;
    end else begin
      sost_q  <= sost;
      count   <= count_n;
      hue     <= hue_n;
      sat     <= sat_n;
      val     <= val_n;
      // Pulse coincides with the new triple; identical rewrites stay silent.
      hsv_upd <= ({hue_n, sat_n, val_n} != {hue, sat, val});
    end
  end

endmodule

// File: tb/tb_hsv_mode_ctrl.sv
module tb_hsv_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sost;
  logic [8:0] sw_h;
  logic [6:0] sw_s;
  logic [6:0] sw_v;
  logic [8:0] hue;
  logic [6:0] sat;
  logic [6:0] val;
  logic       hsv_upd;
  logic       mode_err;

  int tests = 0;
  int fails = 0;

  hsv_mode_ctrl #(
    .STEP_CYCLES(4),
    .HUE_PRESET(120),
    .HUE_JUMP(60),
    .SV_PRESET(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sost(sost),
    .sw_h(sw_h),
    .sw_s(sw_s),
    .sw_v(sw_v),
    .hue(hue),
    .sat(sat),
    .val(val),
    .hsv_upd(hsv_upd),
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1; sost = 4'd0; sw_h = '0; sw_s = '0; sw_v = '0;
    cyc(); cyc();
    reset = 1'b0;
    tests++; if (hue !== 9'd120) begin fails++; $display("FAIL reset_hue got %0d want 120", hue); end
    tests++; if (sat !== 7'd100) begin fails++; $display("FAIL reset_sat got %0d want 100", sat); end
    tests++; if (val !== 7'd100) begin fails++; $display("FAIL reset_val got %0d want 100", val); end
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL reset_upd got %0b want 0", hsv_upd); end
    tests++; if (mode_err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", mode_err); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (hsv_upd === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL idle0_pulses got %0d want 0", pulses); end
    tests++; if (hue !== 9'd120) begin fails++; $display("FAIL idle0_hue got %0d want 120", hue); end
  endtask

  // Mode 1 from hue=120: steps at edges 5,9,13,17,21 after sost changes.
  task automatic test_hue_jump();
    logic [8:0] steps [5] = '{9'd180, 9'd240, 9'd300, 9'd0, 9'd60};
    logic [8:0] exp_hue;
    logic       exp_upd;
    exp_hue = 9'd120;
    sost = 4'd1;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      exp_upd = 1'b0;
      if (k >= 5 && ((k - 1) % 4) == 0) begin
        exp_hue = steps[(k - 5) / 4];
        exp_upd = 1'b1;
      end
      tests++; if (hue !== exp_hue) begin fails++; $display("FAIL jump_hue edge %0d got %0d want %0d", k, hue, exp_hue); end
      tests++; if (hsv_upd !== exp_upd) begin fails++; $display("FAIL jump_upd edge %0d got %0b want %0b", k, hsv_upd, exp_upd); end
    end
  endtask

  task automatic test_hue_creep_wrap();
    sost = 4'd3; sw_h = 9'd358;
    cyc(); cyc();
    tests++; if (hue !== 9'd358) begin fails++; $display("FAIL creep_setup got %0d want 358", hue); end
    sost = 4'd2;
    cyc(); cyc(); cyc(); cyc();
    tests++; if (hue !== 9'd358) begin fails++; $display("FAIL creep_early got %0d want 358", hue); end
    cyc();
    tests++; if (hue !== 9'd359) begin fails++; $display("FAIL creep_359 got %0d want 359", hue); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL creep_upd1 got %0b want 1", hsv_upd); end
    cyc();
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL creep_upd1_off got %0b want 0", hsv_upd); end
    cyc(); cyc(); cyc();
    tests++; if (hue !== 9'd0) begin fails++; $display("FAIL creep_wrap got %0d want 0", hue); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL creep_upd2 got %0b want 1", hsv_upd); end
  endtask

  task automatic test_switches();
    sost = 4'd3; sw_h = 9'd400;
    cyc(); cyc();
    tests++; if (hue !== 9'd359) begin fails++; $display("FAIL sw_h_clamp got %0d want 359", hue); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL sw_h_clamp_upd got %0b want 1", hsv_upd); end
    sw_h = 9'd45;
    cyc();
    tests++; if (hue !== 9'd45) begin fails++; $display("FAIL sw_h_45 got %0d want 45", hue); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL sw_h_45_upd got %0b want 1", hsv_upd); end
    cyc();
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL sw_h_hold_upd got %0b want 0", hsv_upd); end
    sost = 4'd4; sw_v = 7'd30;
    cyc(); cyc();
    tests++; if (val !== 7'd30) begin fails++; $display("FAIL sw_v_30 got %0d want 30", val); end
    tests++; if (hue !== 9'd45) begin fails++; $display("FAIL sw_v_hue_hold got %0d want 45", hue); end
    sw_v = 7'd127;
    cyc();
    tests++; if (val !== 7'd100) begin fails++; $display("FAIL sw_v_clamp got %0d want 100", val); end
    sost = 4'd5; sw_s = 7'd20;
    cyc(); cyc();
    tests++; if (sat !== 7'd20) begin fails++; $display("FAIL sw_s_20 got %0d want 20", sat); end
    tests++; if (val !== 7'd100) begin fails++; $display("FAIL sw_s_val_hold got %0d want 100", val); end
    sw_s = 7'd101;
    cyc();
    tests++; if (sat !== 7'd100) begin fails++; $display("FAIL sw_s_clamp got %0d want 100", sat); end
  endtask

  task automatic test_presets_and_err();
    int pulses;
    sost = 4'd6;
    cyc(); cyc();
    tests++; if (sat !== 7'd50) begin fails++; $display("FAIL sv_preset_sat got %0d want 50", sat); end
    tests++; if (val !== 7'd50) begin fails++; $display("FAIL sv_preset_val got %0d want 50", val); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL sv_preset_upd got %0b want 1", hsv_upd); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (hsv_upd === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL sv_preset_repulse got %0d want 0", pulses); end
    sost = 4'd9;
    cyc();
    tests++; if (mode_err !== 1'b1) begin fails++; $display("FAIL err_high got %0b want 1", mode_err); end
    cyc(); cyc(); cyc();
    tests++; if ({hue, sat, val} !== {9'd45, 7'd50, 7'd50}) begin fails++; $display("FAIL err_hold got %0d/%0d/%0d want 45/50/50", hue, sat, val); end
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL err_upd got %0b want 0", hsv_upd); end
    sost = 4'd0;
    cyc();
    tests++; if (mode_err !== 1'b0) begin fails++; $display("FAIL err_low got %0b want 0", mode_err); end
    cyc();
    tests++; if (hue !== 9'd120) begin fails++; $display("FAIL back_mode0_hue got %0d want 120", hue); end
    tests++; if (hsv_upd !== 1'b1) begin fails++; $display("FAIL back_mode0_upd got %0b want 1", hsv_upd); end
  endtask

  task automatic test_reset_midstep_and_race();
    // hue=120, mode 0. Enter mode 1, reach the 180 step, then count to 2.
    sost = 4'd1;
    for (int k = 1; k <= 5; k++) cyc();
    tests++; if (hue !== 9'd180) begin fails++; $display("FAIL mid_pre got %0d want 180", hue); end
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests++; if (hue !== 9'd120) begin fails++; $display("FAIL mid_reset_hue got %0d want 120", hue); end
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL mid_reset_upd got %0b want 0", hsv_upd); end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      tests++; if (hue !== 9'd120) begin fails++; $display("FAIL mid_post_hold edge %0d got %0d want 120", k, hue); end
    end
    cyc();
    tests++; if (hue !== 9'd180) begin fails++; $display("FAIL mid_post_step got %0d want 180", hue); end
    cyc(); cyc(); cyc();
    sost = 4'd2;  // count now at STEP_CYCLES-1: tick and mode change share the edge
    cyc();
    tests++; if (hue !== 9'd180) begin fails++; $display("FAIL race_no_step got %0d want 180", hue); end
    tests++; if (hsv_upd !== 1'b0) begin fails++; $display("FAIL race_upd got %0b want 0", hsv_upd); end
    cyc(); cyc(); cyc();
    tests++; if (hue !== 9'd180) begin fails++; $display("FAIL race_wait got %0d want 180", hue); end
    cyc();
    tests++; if (hue !== 9'd181) begin fails++; $display("FAIL race_mode2_step got %0d want 181", hue); end
  endtask

  initial begin
    test_reset();
    test_hue_jump();
    test_hue_creep_wrap();
    test_switches();
    test_presets_and_err();
    test_reset_midstep_and_race();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
